// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: frames SPI slave-select periods into words, buffers received
// words in an RX FIFO and presents the host TX word to the front end.
module spi_slave_ctrl #(
  parameter int DATA_W   = 8,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sclk,
  input  logic                      ss,
  input  logic [DATA_W-1:0]         fe_data_out,
  input  logic                      fe_ss_pos_edge,
  input  logic                      fe_ss_neg_edge,
  output logic [DATA_W-1:0]         fe_data_in,
  output logic [DATA_W-1:0]         rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  input  logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic [CNT_W-1:0]          frame_words,
  output logic                      rx_overflow,
  output logic                      tx_underrun,
  output logic                      frame_err,
  input  logic                      clr_err
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [AW:0]   FULL_LVL = (AW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_END} state_t;

  state_t              r_state;
  logic [2:0]          r_sclk_s;
  logic [BW-1:0]       r_bit_cnt;
  logic [CNT_W-1:0]    r_word_cnt;
  logic                r_cap;
  logic                r_busy;
  logic                r_frame_done;
  logic [CNT_W-1:0]    r_frame_words;
  logic [DATA_W-1:0]   r_mem [RX_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic [DATA_W-1:0]   r_tx_hold;
  logic                r_tx_full;
  logic                r_ovf;
  logic                r_udr;
  logic                r_ferr;

  logic w_sclk_rise, w_tick, w_word_done;
  logic w_full, w_pop, w_push_ok, w_set_ovf;
  logic w_tx_load, w_set_udr, w_set_ferr;

  // sclk_rise lines up with the front end's shift cycle
  assign w_sclk_rise = ~r_sclk_s[2] & r_sclk_s[1];
  assign w_tick      = (r_state == S_ACTIVE) & ~ss & w_sclk_rise;
  assign w_word_done = w_tick & (r_bit_cnt == LAST_BIT);

  assign w_full    = (r_count == FULL_LVL);
  assign w_pop     = (r_count != '0) & rx_ready;
  assign w_push_ok = r_cap & (~w_full | w_pop);
  assign w_set_ovf = r_cap & w_full & ~w_pop;

  assign w_tx_load  = tx_valid & ~r_tx_full;
  assign w_set_udr  = w_word_done & ~r_tx_full;
  assign w_set_ferr = (r_state == S_ACTIVE) &
                      (fe_ss_neg_edge | (fe_ss_pos_edge & (r_bit_cnt != '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sclk_s <= '0;
    else      r_sclk_s <= {r_sclk_s[1:0], sclk};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_cap         <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_words <= '0;
    end else begin
      r_cap <= w_word_done;
      case (r_state)
        S_IDLE: begin
          if (fe_ss_neg_edge) begin
            r_state    <= S_ACTIVE;
            r_busy     <= 1'b1;
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
          end
        end
        S_ACTIVE: begin
          if (fe_ss_pos_edge) begin
            r_state      <= S_END;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end else if (fe_ss_neg_edge) begin
            r_bit_cnt  <= '0;
            r_word_cnt <= '0;
          end else if (w_tick) begin
            r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + 1'b1;
            if (w_word_done && (r_word_cnt != '1))
              r_word_cnt <= r_word_cnt + 1'b1;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_frame_done  <= 1'b0;
          r_frame_words <= r_word_cnt;
        end
      endcase
    end
  end

  // A push on a full FIFO is accepted when the head is popped in the same cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < unsigned'(RX_DEPTH); i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= fe_data_out;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_hold <= '0;
      r_tx_full <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_hold <= tx_data;
      r_tx_full <= 1'b1;
    end else if (w_word_done && r_tx_full) begin
      r_tx_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf  <= 1'b0;
      r_udr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_ovf  <= (r_ovf  & ~clr_err) | w_set_ovf;
      r_udr  <= (r_udr  & ~clr_err) | w_set_udr;
      r_ferr <= (r_ferr & ~clr_err) | w_set_ferr;
    end
  end

  assign fe_data_in  = r_tx_hold;
  assign rx_data     = r_mem[r_rd_ptr];
  assign rx_valid    = (r_count != '0);
  assign rx_level    = r_count;
  assign tx_ready    = ~r_tx_full;
  assign busy        = r_busy;
  assign frame_done  = r_frame_done;
  assign frame_words = r_frame_words;
  assign rx_overflow = r_ovf;
  assign tx_underrun = r_udr;
  assign frame_err   = r_ferr;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Bench for spi_slave_ctrl: a small front-end model drives the parallel side,
// received words and flags are predicted from frame contents.
module tb_spi_slave_ctrl;
  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
  logic [7:0] fe_data_out, fe_data_in, rx_data, tx_data = '0;
  logic       fe_ss_pos_edge, fe_ss_neg_edge;
  logic       rx_valid, rx_ready = 1'b0, tx_valid = 1'b0, tx_ready;
  logic [2:0] rx_level;
  logic       busy, frame_done, rx_overflow, tx_underrun, frame_err, clr_err = 1'b0;
  logic [15:0] frame_words;

  int checks = 0, passes = 0;
  logic [7:0] frame_bytes [8];
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;
  bit         exp_ovf;
  bit         fd_seen, fd_after;

  spi_slave_ctrl #(.DATA_W(8), .RX_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss(ss),
    .fe_data_out(fe_data_out), .fe_ss_pos_edge(fe_ss_pos_edge),
    .fe_ss_neg_edge(fe_ss_neg_edge), .fe_data_in(fe_data_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_level(rx_level), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
    .frame_words(frame_words), .rx_overflow(rx_overflow),
    .tx_underrun(tx_underrun), .frame_err(frame_err), .clr_err(clr_err));

  always #5 clk = ~clk;

  // Front end: samples sclk/ss through 3 flops, shifts MOSI in MSB first
  logic [2:0] fe_sclk_s, fe_ss_s;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fe_sclk_s <= '0; fe_ss_s <= '1; fe_data_out <= '0;
    end else begin
      fe_sclk_s <= {fe_sclk_s[1:0], sclk};
      fe_ss_s   <= {fe_ss_s[1:0], ss};
      if (~fe_sclk_s[2] & fe_sclk_s[1] & ~ss) fe_data_out <= {fe_data_out[6:0], mosi};
    end
  end
  assign fe_ss_neg_edge = fe_ss_s[2] & ~fe_ss_s[1];
  assign fe_ss_pos_edge = ~fe_ss_s[2] & fe_ss_s[1];

  function automatic void model_frame(input int nbits);
    for (int i = 0; i < nbits / 8; i++) begin
      if (exp_q.size() < 4) exp_q.push_back(frame_bytes[i]);
      else exp_ovf = 1'b1;
    end
  endfunction

  task automatic spi_bit(input logic b);
    sclk = 1'b0; mosi = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
  endtask

  task automatic send_bits(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      spi_bit(frame_bytes[i/8][7-(i%8)]);
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic frame_start();
    @(negedge clk); ss = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic frame_end();
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    fd_seen = 1'b0;
    for (int k = 0; k < 12 && !fd_seen; k++) begin
      @(negedge clk);
      if (frame_done === 1'b1) fd_seen = 1'b1;
    end
    @(negedge clk); fd_after = frame_done;
    repeat (2) @(negedge clk);
  endtask

  task automatic tx_load(input logic [7:0] v);
    tx_data = v; tx_valid = 1'b1;
    @(negedge clk); tx_valid = 1'b0;
  endtask

  task automatic pop();
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0; #1;
    checks++; if ({rx_valid, rx_level, tx_ready, busy, frame_done} !== 7'b0_000_1_0_0)
      $display("FAIL reset_ctl: got %b expected 0000100", {rx_valid, rx_level, tx_ready, busy, frame_done}); else passes++;
    checks++; if ({frame_words, fe_data_in, rx_overflow, tx_underrun, frame_err} !== 27'd0)
      $display("FAIL reset_data: got words=%h fe=%h flags=%b expected all 0", frame_words, fe_data_in, {rx_overflow, tx_underrun, frame_err}); else passes++;
    repeat (3) @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    frame_bytes[0] = 8'($urandom);
    frame_start(); send_bits(0, 8); frame_end();
    tx_load(8'h55);
    frame_start(); send_bits(0, 3);
    checks++; if ({busy, rx_level, tx_ready, tx_underrun, frame_words} !== {1'b1, 3'd1, 1'b0, 1'b1, 16'd1})
      $display("FAIL pre_reset: got busy=%b lvl=%0d trdy=%b udr=%b words=%0d expected 1/1/0/1/1", busy, rx_level, tx_ready, tx_underrun, frame_words); else passes++;
    #2 rst = 1'b0; #1;
    checks++; if ({busy, rx_valid, rx_level, tx_ready, frame_done} !== 7'b0_0_000_1_0)
      $display("FAIL mid_reset_ctl: got busy=%b vld=%b lvl=%0d trdy=%b fd=%b expected 0/0/0/1/0", busy, rx_valid, rx_level, tx_ready, frame_done); else passes++;
    checks++; if ({frame_words, fe_data_in, rx_overflow, tx_underrun, frame_err} !== 27'd0)
      $display("FAIL mid_reset_data: got words=%h fe=%h flags=%b expected all 0", frame_words, fe_data_in, {rx_overflow, tx_underrun, frame_err}); else passes++;
    ss = 1'b1; sclk = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete(); exp_ovf = 1'b0;
  endtask

  task automatic test_single_frame();
    frame_bytes[0] = 8'hA5;
    tx_load(8'h3C);
    checks++; if (tx_ready !== 1'b0 || fe_data_in !== 8'h3C)
      $display("FAIL tx_preload: got rdy=%b fe=%h expected 0/3c", tx_ready, fe_data_in); else passes++;
    frame_start();
    checks++; if (busy !== 1'b1) $display("FAIL busy_active: got %b expected 1", busy); else passes++;
    send_bits(0, 7);
    spi_bit(frame_bytes[0][0]);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++; if (rx_valid !== (c == 4))
        $display("FAIL rx_valid_edge%0d: got %b expected %b", c, rx_valid, (c == 4)); else passes++;
    end
    checks++; if (rx_data !== 8'hA5 || tx_ready !== 1'b1 || fe_data_in !== 8'h3C || tx_underrun !== 1'b0)
      $display("FAIL single_word: got rx=%h trdy=%b fe=%h udr=%b expected a5/1/3c/0", rx_data, tx_ready, fe_data_in, tx_underrun); else passes++;
    frame_end();
    checks++; if (fd_seen !== 1'b1 || fd_after !== 1'b0)
      $display("FAIL frame_done_pulse: got seen=%b after=%b expected 1/0", fd_seen, fd_after); else passes++;
    checks++; if (frame_words !== 16'd1 || frame_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL single_end: got words=%0d ferr=%b busy=%b expected 1/0/0", frame_words, frame_err, busy); else passes++;
    pop();
    checks++; if (rx_level !== 3'd0) $display("FAIL single_drain: got %0d expected 0", rx_level); else passes++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) frame_bytes[i] = 8'($urandom);
    frame_start(); send_bits(0, 48); frame_end();
    model_frame(48);
    checks++; if (rx_level !== 3'd4 || rx_overflow !== exp_ovf || tx_underrun !== 1'b1 || frame_words !== 16'd6)
      $display("FAIL overflow_state: got lvl=%0d ovf=%b udr=%b words=%0d expected 4/%b/1/6", rx_level, rx_overflow, tx_underrun, frame_words, exp_ovf); else passes++;
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_v)
        $display("FAIL overflow_word%0d: got vld=%b data=%h expected 1/%h", i, rx_valid, rx_data, exp_v); else passes++;
      pop();
    end
    clr_pulse();
    checks++; if ({rx_overflow, tx_underrun, rx_level} !== 5'd0)
      $display("FAIL clr_err: got ovf=%b udr=%b lvl=%0d expected 0/0/0", rx_overflow, tx_underrun, rx_level); else passes++;
  endtask

  task automatic test_partial();
    frame_bytes[0] = 8'($urandom); frame_bytes[1] = 8'($urandom);
    frame_start(); send_bits(0, 12); frame_end();
    model_frame(12);
    checks++; if (frame_err !== 1'b1 || frame_words !== 16'd1 || rx_level !== 3'd1)
      $display("FAIL partial: got ferr=%b words=%0d lvl=%0d expected 1/1/1", frame_err, frame_words, rx_level); else passes++;
    exp_v = exp_q.pop_front();
    checks++; if (rx_data !== exp_v) $display("FAIL partial_data: got %h expected %h", rx_data, exp_v); else passes++;
    pop(); clr_pulse();
  endtask

  task automatic test_underrun();
    logic [7:0] w1;
    w1 = 8'($urandom);
    frame_bytes[0] = 8'($urandom); frame_bytes[1] = 8'($urandom);
    tx_load(w1);
    frame_start(); send_bits(0, 8);
    checks++; if (tx_ready !== 1'b1 || tx_underrun !== 1'b0)
      $display("FAIL udr_first: got rdy=%b udr=%b expected 1/0", tx_ready, tx_underrun); else passes++;
    send_bits(8, 8);
    checks++; if (tx_underrun !== 1'b1 || fe_data_in !== w1)
      $display("FAIL udr_second: got udr=%b fe=%h expected 1/%h", tx_underrun, fe_data_in, w1); else passes++;
    frame_end();
    model_frame(16);
    for (int i = 0; i < 2; i++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_v)
        $display("FAIL udr_word%0d: got vld=%b data=%h expected 1/%h", i, rx_valid, rx_data, exp_v); else passes++;
      pop();
    end
    clr_pulse();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < 4; i++) frame_bytes[i] = 8'($urandom);
    frame_start(); send_bits(0, 32); frame_end();
    model_frame(32);
    frame_bytes[0] = 8'($urandom);
    frame_start(); send_bits(0, 7);
    spi_bit(frame_bytes[0][0]);
    repeat (3) @(negedge clk);
    rx_ready = 1'b1;
    exp_v = exp_q.pop_front();
    checks++; if (rx_data !== exp_v || rx_level !== 3'd4)
      $display("FAIL pushpop_head: got data=%h lvl=%0d expected %h/4", rx_data, rx_level, exp_v); else passes++;
    @(negedge clk); rx_ready = 1'b0;
    model_frame(8);
    checks++; if (rx_level !== 3'd4 || rx_overflow !== 1'b0)
      $display("FAIL pushpop_full: got lvl=%0d ovf=%b expected 4/0", rx_level, rx_overflow); else passes++;
    frame_end();
    for (int i = 0; i < 4; i++) begin
      exp_v = exp_q.pop_front();
      checks++; if (rx_valid !== 1'b1 || rx_data !== exp_v)
        $display("FAIL pushpop_word%0d: got vld=%b data=%h expected 1/%h", i, rx_valid, rx_data, exp_v); else passes++;
      pop();
    end
    clr_pulse();
  endtask

  task automatic test_random_frames();
    int nw, extra;
    logic [7:0] txv;
    for (int it = 0; it < 4; it++) begin
      nw = $urandom_range(1, 3);
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      for (int i = 0; i < 4; i++) frame_bytes[i] = 8'($urandom);
      txv = 8'($urandom);
      tx_load(txv);
      frame_start(); send_bits(0, nw * 8 + extra); frame_end();
      model_frame(nw * 8 + extra);
      checks++; if (frame_words !== 16'(nw) || frame_err !== (extra != 0) || tx_underrun !== (nw > 1) || fe_data_in !== txv || rx_level !== 3'(nw))
        $display("FAIL rand%0d_status: got words=%0d ferr=%b udr=%b fe=%h lvl=%0d expected %0d/%b/%b/%h/%0d", it, frame_words, frame_err, tx_underrun, fe_data_in, rx_level, nw, (extra != 0), (nw > 1), txv, nw); else passes++;
      for (int i = 0; i < nw; i++) begin
        exp_v = exp_q.pop_front();
        checks++; if (rx_valid !== 1'b1 || rx_data !== exp_v)
          $display("FAIL rand%0d_word%0d: got vld=%b data=%h expected 1/%h", it, i, rx_valid, rx_data, exp_v); else passes++;
        pop();
      end
      if (nw == 1) begin
        spi_bit(1'b0); sclk = 1'b0;
      end
      clr_pulse();
      if (!tx_ready) begin
        frame_start(); send_bits(0, 8); frame_end();
        model_frame(8);
        exp_v = exp_q.pop_front(); pop(); clr_pulse();
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_midframe();
    test_single_frame();
    test_overflow();
    test_partial();
    test_underrun();
    test_full_pushpop();
    test_random_frames();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
